// File: rtl/clusterv_mailbox_wb.sv
// Wishbone-slave mailbox: a DEPTH-word FIFO behind DATA/STATUS/IRQ_EN/CTRL registers with a level interrupt.
// Optional build macro CLUSTERV_MAILBOX_ERR_EN: full-push and empty-pop terminate with t_err instead of t_ack.
module clusterv_mailbox_wb #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] t_adr,
    input  logic [31:0] t_dat_w,
    output logic [31:0] t_dat_r,
    input  logic        t_cyc,
    input  logic        t_stb,
    input  logic        t_we,
    input  logic [3:0]  t_sel,
    input  logic        t_tga,
    input  logic        t_tgd_w,
    input  logic [3:0]  t_tgc,
    output logic        t_tgd_r,
    output logic        t_ack,
    output logic        t_err,
    output logic        irq
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state, state_next;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            irq_en;

    logic            req_c, full_c, empty_c;
    logic [1:0]      reg_sel_c;
    logic            push_c, pop_c, push_full_c;
    logic            ctrl_wr_c, irq_en_wr_c;
    logic [31:0]     wdata_c, rdata_c, status_c;

    logic unused_inputs;
    assign unused_inputs = ^{t_adr[31:4], t_adr[1:0], t_tga, t_tgd_w, t_tgc};

    assign t_tgd_r = 1'b0;
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == CW'(0));
    assign irq     = irq_en && !empty_c;

    // Next-state logic; RESP always returns to IDLE so requests are ignored there
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (t_cyc && t_stb) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request decode and read mux, all evaluated on the IDLE->RESP edge
    always_comb begin
        req_c       = (state == IDLE) && t_cyc && t_stb;
        reg_sel_c   = t_adr[3:2];
        push_c      = req_c && t_we  && (reg_sel_c == 2'd0) && !full_c;
        push_full_c = req_c && t_we  && (reg_sel_c == 2'd0) && full_c;
        pop_c       = req_c && !t_we && (reg_sel_c == 2'd0) && !empty_c;
        ctrl_wr_c   = req_c && t_we  && (reg_sel_c == 2'd3);
        irq_en_wr_c = req_c && t_we  && (reg_sel_c == 2'd2);
        wdata_c     = t_dat_w & {{8{t_sel[3]}}, {8{t_sel[2]}}, {8{t_sel[1]}}, {8{t_sel[0]}}};

        status_c           = 32'd0;
        status_c[CW-1:0]   = count;
        status_c[8]        = full_c;
        status_c[9]        = empty_c;
        status_c[16]       = ovf;

        rdata_c = 32'd0;
        case (reg_sel_c)
            2'd0:    rdata_c = empty_c ? 32'd0 : mem[rptr];
            2'd1:    rdata_c = status_c;
            2'd2:    rdata_c = {31'd0, irq_en};
            default: rdata_c = 32'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FIFO storage is not reset; validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (push_c) mem[wptr] <= wdata_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (ctrl_wr_c && t_dat_w[0]) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else if (push_c) begin
                wptr  <= wptr + PW'(1);
                count <= count + CW'(1);
            end else if (pop_c) begin
                rptr  <= rptr + PW'(1);
                count <= count - CW'(1);
            end
            if (push_full_c)                     ovf <= 1'b1;
            else if (ctrl_wr_c && t_dat_w[1])    ovf <= 1'b0;
            if (irq_en_wr_c) irq_en <= t_dat_w[0];
        end
    end

    // Read data holds until the next read; writes never disturb it
    always_ff @(posedge clock or posedge reset) begin
        if (reset)               t_dat_r <= 32'd0;
        else if (req_c && !t_we) t_dat_r <= rdata_c;
    end

`ifdef CLUSTERV_MAILBOX_ERR_EN
    logic pop_empty_c, bad_c;
    assign pop_empty_c = req_c && !t_we && (reg_sel_c == 2'd0) && empty_c;
    assign bad_c       = push_full_c || pop_empty_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_ack <= 1'b0;
            t_err <= 1'b0;
        end else begin
            t_ack <= req_c && !bad_c;
            t_err <= req_c && bad_c;
        end
    end
`else
    assign t_err = 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) t_ack <= 1'b0;
        else       t_ack <= req_c;
    end
`endif

endmodule

// File: tb/tb_clusterv_mailbox_wb.sv
// Scoreboard bench for clusterv_mailbox_wb: bus tasks queue expected terminations, a negedge monitor checks them.
module tb_clusterv_mailbox_wb;

    localparam int unsigned DEPTH = 8;
`ifdef CLUSTERV_MAILBOX_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] t_adr, t_dat_w, t_dat_r;
    logic        t_cyc, t_stb, t_we;
    logic [3:0]  t_sel;
    logic        t_tga, t_tgd_w, t_tgd_r;
    logic [3:0]  t_tgc;
    logic        t_ack, t_err, irq;

    clusterv_mailbox_wb #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
        .t_tga(t_tga), .t_tgd_w(t_tgd_w), .t_tgc(t_tgc), .t_tgd_r(t_tgd_r),
        .t_ack(t_ack), .t_err(t_err), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every termination strobe consumes one scoreboard entry
    always @(negedge clock) begin
        if (reset === 1'b0 && (t_ack === 1'b1 || t_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b expected no response", t_ack, t_err);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_err"}, 32'(t_err), 32'(mon_e.err));
                check({mon_e.name, "_ack"}, 32'(t_ack), 32'(!mon_e.err));
                if (mon_e.chk) check({mon_e.name, "_data"}, t_dat_r, mon_e.data);
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic exp_err, input logic chk,
                          input logic [31:0] exp_data, input string name);
        exp_t e;
        e.err = exp_err; e.chk = chk; e.data = exp_data; e.name = name;
        exp_q.push_back(e);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_adr = adr; t_dat_w = dat; t_sel = sel;
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic exp_err, input string name);
        access(1'b1, adr, dat, 4'hF, exp_err, 1'b0, 32'd0, name);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_data, input logic exp_err, input string name);
        access(1'b0, adr, 32'd0, 4'hF, exp_err, 1'b1, exp_data, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; t_adr = '0; t_dat_w = '0; t_cyc = 0; t_stb = 0; t_we = 0;
        t_sel = 4'hF; t_tga = 1'b1; t_tgd_w = 1'b1; t_tgc = 4'hA;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ack", 32'(t_ack), 32'd0);
        check("rst_err", 32'(t_err), 32'd0);
        check("rst_dat_r", t_dat_r, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("tgd_r", 32'(t_tgd_r), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        rd(32'h4, 32'h200, 1'b0, "status_reset");

        // Push/pop ordering
        wr(32'h0, 32'h11111111, 1'b0, "push1");
        wr(32'h0, 32'h22222222, 1'b0, "push2");
        rd(32'h4, 32'h002, 1'b0, "status_two");
        rd(32'h0, 32'h11111111, 1'b0, "pop1");
        rd(32'h0, 32'h22222222, 1'b0, "pop2");
        rd(32'h4, 32'h200, 1'b0, "status_empty");

        // Byte mask, then read data must survive a write
        access(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'd0, "push_mask");
        rd(32'h0, 32'h00BB00DD, 1'b0, "pop_mask");
        wr(32'h8, 32'h0, 1'b0, "irq_en_wr0");
        check("dat_r_hold", t_dat_r, 32'h00BB00DD);

        // Empty pop
        rd(32'h0, 32'h0, ERR_EN, "pop_empty");
        rd(32'h4, 32'h200, 1'b0, "status_after_empty_pop");

        // Overflow
        for (int i = 0; i < 8; i++) wr(32'h0, 32'h100 + 32'(i), 1'b0, "ovf_fill");
        wr(32'h0, 32'hDEADBEEF, ERR_EN, "ovf_push9");
        rd(32'h4, 32'h10108, 1'b0, "status_ovf");
        wr(32'hC, 32'h2, 1'b0, "ctrl_clr_ovf");
        rd(32'h4, 32'h00108, 1'b0, "status_ovf_clr");
        for (int i = 0; i < 8; i++) rd(32'h0, 32'h100 + 32'(i), 1'b0, "ovf_drain");
        rd(32'h4, 32'h200, 1'b0, "status_drained");

        // Interrupt
        wr(32'h8, 32'hFFFFFFFF, 1'b0, "irq_en_wr");
        rd(32'h8, 32'h1, 1'b0, "irq_en_rd");
        check("irq_empty", 32'(irq), 32'd0);
        wr(32'h0, 32'h5, 1'b0, "irq_push");
        check("irq_after_push", 32'(irq), 32'd1);
        rd(32'h0, 32'h5, 1'b0, "irq_pop");
        check("irq_after_pop", 32'(irq), 32'd0);
        wr(32'h0, 32'h6, 1'b0, "irq_push2");
        check("irq_after_push2", 32'(irq), 32'd1);
        wr(32'hC, 32'h1, 1'b0, "ctrl_flush");
        check("irq_after_flush", 32'(irq), 32'd0);
        rd(32'h4, 32'h200, 1'b0, "status_flushed");
        rd(32'hC, 32'h0, 1'b0, "ctrl_read");

        // Pointer wrap
        for (int i = 0; i < 20; i++) begin
            wr(32'h0, 32'hC0DE0000 + 32'(i), 1'b0, "wrap_push");
            rd(32'h0, 32'hC0DE0000 + 32'(i), 1'b0, "wrap_pop");
        end
        rd(32'h4, 32'h200, 1'b0, "status_wrap");

        // Reset in the ack cycle (irq_en still 1)
        wr(32'h0, 32'h77, 1'b0, "pre_rst_push");
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h4;
        @(posedge clock); #1;
        check("resp_ack_before_rst", 32'(t_ack), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_resp_ack", 32'(t_ack), 32'd0);
        check("rst_resp_err", 32'(t_err), 32'd0);
        check("rst_resp_irq", 32'(irq), 32'd0);
        t_cyc = 1'b0; t_stb = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        rd(32'h4, 32'h200, 1'b0, "status_after_rst");
        rd(32'h8, 32'h0, 1'b0, "irq_en_after_rst");

        repeat (2) @(posedge clock);
        check("pending_resp", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
